// File: rtl/sprite_lane_controller.sv
// Falling-object lane controller: per-lane position/visibility, hit scoring, miss tracking,
// game-over detection and staggered spawning for the VGA sprite datapath.
module sprite_lane_controller #(
  parameter int unsigned N_LANES     = 10,
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned Y_MAX       = 119,
  parameter int unsigned LANE_PITCH  = 16,
  parameter int unsigned OFFSET_MASK = 7,
  parameter int unsigned RATE_W      = 2,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned MISS_LIMIT  = 3,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         frame_tick,
  input  logic [$clog2(N_LANES+1)-1:0] active_count,
  input  logic [RATE_W-1:0]            rate,
  input  logic [N_LANES-1:0]           hit,
  output logic [N_LANES*COORD_W-1:0]   x_bus,
  output logic [N_LANES*COORD_W-1:0]   y_bus,
  output logic [N_LANES-1:0]           vis,
  output logic [SCORE_W-1:0]           score,
  output logic [3:0]                   misses,
  output logic                         running,
  output logic                         game_over
);

  typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

  state_e                       state_q, state_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic [N_LANES*COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [N_LANES-1:0]           vis_q, vis_d;
  logic [SCORE_W-1:0]           score_q, score_d;
  logic [3:0]                   miss_q, miss_d;
  logic [4:0]                   n_hit, n_miss;
  logic                         spawned;
  logic [SCORE_W+4:0]           score_sum;
  logic [5:0]                   miss_sum;

  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vis_d     = vis_q;
    score_d   = score_q;
    miss_d    = miss_q;
    n_hit     = '0;
    n_miss    = '0;
    spawned   = 1'b0;
    score_sum = '0;
    miss_sum  = '0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          vis_d   = '0;
          y_d     = '0;
          score_d = '0;
          miss_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < N_LANES; i++) begin
          logic               en;
          logic [COORD_W:0]   y_next;
          en     = 32'(active_count) > i;
          y_next = {1'b0, y_q[i*COORD_W +: COORD_W]} + (COORD_W+1)'(rate) + (COORD_W+1)'(1);
          // Priority: disable > hit > edge/move > spawn
          if (vis_q[i] && !en) begin
            vis_d[i]                 = 1'b0;
            y_d[i*COORD_W +: COORD_W] = '0;
          end else if (en && vis_q[i] && hit[i]) begin
            vis_d[i]                 = 1'b0;
            y_d[i*COORD_W +: COORD_W] = '0;
            n_hit                    = n_hit + 5'd1;
          end else if (en && frame_tick && vis_q[i]) begin
            if (y_next >= (COORD_W+1)'(Y_MAX)) begin
              vis_d[i]                 = 1'b0;
              y_d[i*COORD_W +: COORD_W] = '0;
              n_miss                   = n_miss + 5'd1;
            end else begin
              y_d[i*COORD_W +: COORD_W] = y_next[COORD_W-1:0];
            end
          end else if (en && frame_tick && !vis_q[i] && !spawned) begin
            spawned                  = 1'b1;
            vis_d[i]                 = 1'b1;
            y_d[i*COORD_W +: COORD_W] = '0;
            x_d[i*COORD_W +: COORD_W] = COORD_W'(i * LANE_PITCH) +
                                        (lfsr_q[COORD_W-1:0] & COORD_W'(OFFSET_MASK));
          end
        end

        score_sum = (SCORE_W+5)'(score_q) + (SCORE_W+5)'(n_hit);
        if (score_sum > (SCORE_W+5)'({SCORE_W{1'b1}})) score_d = {SCORE_W{1'b1}};
        else                                           score_d = score_sum[SCORE_W-1:0];

        miss_sum = 6'(miss_q) + 6'(n_miss);
        if (miss_sum >= 6'(MISS_LIMIT)) miss_d = 4'(MISS_LIMIT);
        else                            miss_d = miss_sum[3:0];

        if (miss_d == 4'(MISS_LIMIT)) state_d = StOver;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      x_q     <= '0;
      y_q     <= '0;
      vis_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      score_q <= score_d;
      miss_q  <= miss_d;
    end
  end

  assign x_bus     = x_q;
  assign y_bus     = y_q;
  assign vis       = vis_q;
  assign score     = score_q;
  assign misses    = miss_q;
  assign running   = (state_q == StRun);
  assign game_over = (state_q == StOver);

endmodule

// File: tb/tb_sprite_lane_controller.sv
// Directed self-checking bench for sprite_lane_controller with default parameters.
module tb_sprite_lane_controller;

  localparam int N = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, start, frame_tick;
  logic [3:0]    active_count;
  logic [1:0]    rate;
  logic [N-1:0]  hit;
  logic [N*CW-1:0] x_bus, y_bus;
  logic [N-1:0]  vis;
  logic [7:0]    score;
  logic [3:0]    misses;
  logic          running, game_over;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] lfsr_m;

  sprite_lane_controller dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .frame_tick   (frame_tick),
    .active_count (active_count),
    .rate         (rate),
    .hit          (hit),
    .x_bus        (x_bus),
    .y_bus        (y_bus),
    .vis          (vis),
    .score        (score),
    .misses       (misses),
    .running      (running),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  // Independent model of the Galois LFSR (taps 16,14,13,11)
  always @(posedge clk) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane_y(input int i);
    return y_bus[i*CW +: CW];
  endfunction

  function automatic logic [7:0] lane_x(input int i);
    return x_bus[i*CW +: CW];
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; active_count = 4'd0; rate = 2'd0; hit = '0;
    clk1(); clk1();
    n_checks++;
    if ({x_bus, y_bus, vis, score, misses, running, game_over} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vis=%b score=%0d misses=%0d run=%b over=%b x=%h y=%h, want all 0",
               vis, score, misses, running, game_over, x_bus, y_bus);
    end
    reset = 1'b0;
    frame_tick = 1'b1; active_count = 4'd3;
    clk1(); clk1(); clk1();
    frame_tick = 1'b0;
    n_checks++;
    if ({vis, y_bus, running} !== '0) begin
      n_fail++;
      $display("FAIL idle_ticks: got vis=%b run=%b y=%h, want 0", vis, running, y_bus);
    end
  endtask

  task automatic test_fall();
    logic [7:0] exp_x;
    active_count = 4'd1; rate = 2'd0; start = 1'b1;
    clk1();
    start = 1'b0;
    n_checks++;
    if (running !== 1'b1 || vis !== '0) begin
      n_fail++;
      $display("FAIL start_run: got run=%b vis=%b, want 1/0", running, vis);
    end
    exp_x = 8'(lfsr_m[7:0] & 8'd7);
    frame_tick = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      clk1();
      if (k == 1) begin
        n_checks++;
        if (vis[0] !== 1'b1 || lane_y(0) !== 8'd0 || lane_x(0) !== exp_x) begin
          n_fail++;
          $display("FAIL spawn_lane0: got vis0=%b y=%0d x=%0d, want 1/0/%0d",
                   vis[0], lane_y(0), lane_x(0), exp_x);
        end
      end
      if (k == 119) begin
        n_checks++;
        if (vis[0] !== 1'b1 || lane_y(0) !== 8'd118) begin
          n_fail++;
          $display("FAIL fall_118: got vis0=%b y=%0d, want 1/118", vis[0], lane_y(0));
        end
      end
      if (k == 120) begin
        n_checks++;
        if (vis[0] !== 1'b0 || misses !== 4'd1 || score !== 8'd0 || running !== 1'b1) begin
          n_fail++;
          $display("FAIL bottom_miss: got vis0=%b misses=%0d score=%0d run=%b, want 0/1/0/1",
                   vis[0], misses, score, running);
        end
      end
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_stagger();
    logic [7:0] ex0, ex1, ex2;
    active_count = 4'd3; rate = 2'd3; frame_tick = 1'b1;
    ex0 = 8'(lfsr_m[7:0] & 8'd7);
    clk1();
    n_checks++;
    if (vis[2:0] !== 3'b001 || lane_y(0) !== 8'd0 || lane_x(0) !== ex0) begin
      n_fail++;
      $display("FAIL stagger_t1: got vis=%b y0=%0d x0=%0d, want 001/0/%0d",
               vis[2:0], lane_y(0), lane_x(0), ex0);
    end
    ex1 = 8'd16 + 8'(lfsr_m[7:0] & 8'd7);
    clk1();
    n_checks++;
    if (vis[2:0] !== 3'b011 || lane_y(0) !== 8'd4 || lane_y(1) !== 8'd0 || lane_x(1) !== ex1) begin
      n_fail++;
      $display("FAIL stagger_t2: got vis=%b y0=%0d y1=%0d x1=%0d, want 011/4/0/%0d",
               vis[2:0], lane_y(0), lane_y(1), lane_x(1), ex1);
    end
    ex2 = 8'd32 + 8'(lfsr_m[7:0] & 8'd7);
    clk1();
    frame_tick = 1'b0;
    n_checks++;
    if (vis[2:0] !== 3'b111 || lane_y(0) !== 8'd8 || lane_y(1) !== 8'd4 || lane_y(2) !== 8'd0 ||
        lane_x(2) !== ex2 || lane_x(2) < 8'd32 || lane_x(2) > 8'd39) begin
      n_fail++;
      $display("FAIL stagger_t3: got vis=%b y=%0d,%0d,%0d x2=%0d, want 111/8,4,0/%0d",
               vis[2:0], lane_y(0), lane_y(1), lane_y(2), lane_x(2), ex2);
    end
  endtask

  task automatic test_hit();
    hit = 10'b0000000101;
    clk1();
    n_checks++;
    if (vis[2:0] !== 3'b010 || score !== 8'd2 || lane_y(0) !== 8'd0 || lane_y(2) !== 8'd0) begin
      n_fail++;
      $display("FAIL hit_two: got vis=%b score=%0d y0=%0d y2=%0d, want 010/2/0/0",
               vis[2:0], score, lane_y(0), lane_y(2));
    end
    hit = 10'b0000100001;
    clk1();
    n_checks++;
    if (vis[2:0] !== 3'b010 || score !== 8'd2) begin
      n_fail++;
      $display("FAIL hit_invisible: got vis=%b score=%0d, want 010/2", vis[2:0], score);
    end
    // Hit beats motion on lane 1; lane 0 is lowest eligible so it spawns
    hit = 10'b0000000010; frame_tick = 1'b1;
    clk1();
    hit = '0; frame_tick = 1'b0;
    n_checks++;
    if (vis[2:0] !== 3'b001 || score !== 8'd3 || lane_y(1) !== 8'd0 || misses !== 4'd1) begin
      n_fail++;
      $display("FAIL hit_with_tick: got vis=%b score=%0d y1=%0d misses=%0d, want 001/3/0/1",
               vis[2:0], score, lane_y(1), misses);
    end
  endtask

  task automatic test_game_over();
    active_count = 4'd1; rate = 2'd3; frame_tick = 1'b1;
    for (int n = 0; n < 200 && misses == 4'd1; n++) clk1();
    n_checks++;
    if (misses !== 4'd2 || running !== 1'b1 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL second_miss: got misses=%0d run=%b over=%b, want 2/1/0",
               misses, running, game_over);
    end
    for (int n = 0; n < 200 && misses == 4'd2; n++) clk1();
    n_checks++;
    if (misses !== 4'd3 || running !== 1'b0 || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL game_over: got misses=%0d run=%b over=%b, want 3/0/1",
               misses, running, game_over);
    end
    hit = '1; active_count = 4'd10;
    clk1(); clk1(); clk1();
    hit = '0; frame_tick = 1'b0;
    n_checks++;
    if (vis !== '0 || y_bus !== '0 || score !== 8'd3 || misses !== 4'd3 || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL over_frozen: got vis=%b score=%0d misses=%0d over=%b, want 0/3/3/1",
               vis, score, misses, game_over);
    end
    start = 1'b1;
    clk1();
    start = 1'b0;
    n_checks++;
    if (score !== 8'd0 || misses !== 4'd0 || running !== 1'b1 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: got score=%0d misses=%0d run=%b over=%b, want 0/0/1/0",
               score, misses, running, game_over);
    end
  endtask

  task automatic test_disable();
    active_count = 4'd3; rate = 2'd0; frame_tick = 1'b1;
    clk1(); clk1(); clk1();
    frame_tick = 1'b0;
    n_checks++;
    if (vis !== 10'b0000000111) begin
      n_fail++;
      $display("FAIL three_spawn: got vis=%b, want 0000000111", vis);
    end
    active_count = 4'd2;
    clk1();
    n_checks++;
    if (vis[2:0] !== 3'b011 || lane_y(2) !== 8'd0 || score !== 8'd0 || misses !== 4'd0) begin
      n_fail++;
      $display("FAIL disable_lane2: got vis=%b y2=%0d score=%0d misses=%0d, want 011/0/0/0",
               vis[2:0], lane_y(2), score, misses);
    end
    // Count above N_LANES enables every lane
    active_count = 4'd15; frame_tick = 1'b1;
    for (int k = 0; k < 8; k++) clk1();
    frame_tick = 1'b0;
    n_checks++;
    if (vis !== '1) begin
      n_fail++;
      $display("FAIL over_count: got vis=%b, want all ones", vis);
    end
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    n_checks++;
    if ({x_bus, y_bus, vis, score, misses, running, game_over} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got vis=%b score=%0d run=%b x=%h, want all 0",
               vis, score, running, x_bus);
    end
    frame_tick = 1'b1;
    clk1(); clk1();
    frame_tick = 1'b0;
    n_checks++;
    if (vis !== '0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got vis=%b run=%b, want 0/0", vis, running);
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_stagger();
    test_hit();
    test_game_over();
    test_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_lane_controller.md
Name: sprite_lane_controller

Overview:
Parametrised successor to the fixed 10-plane falling-object controller. Manages N_LANES falling objects, each with its own x/y position and visibility. Adds per-lane hit input, saturating score and miss counters, a game-over state and staggered spawning. Sits between user-input logic (start, rate, active count, hit detection) and the VGA drawing datapath, which consumes the packed coordinate buses.

Parameters:
N_LANES, 10, number of object lanes (1..16)
COORD_W, 8, width of each x and y coordinate
Y_MAX, 119, bottom-edge y; an object whose next y is >= Y_MAX is missed
LANE_PITCH, 16, x spacing between lane bases (x base = lane*LANE_PITCH)
OFFSET_MASK, 7, mask applied to LFSR bits for random x offset within a lane
RATE_W, 2, width of fall-rate input
SCORE_W, 8, score counter width
MISS_LIMIT, 3, misses that end the game (1..15)
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level; sampled each clock, starts or restarts a game
frame_tick  in  1  one-cycle pulse; advances object motion
active_count  in  $clog2(N_LANES+1)  lanes with index < active_count are enabled
rate  in  RATE_W  fall step per tick = rate+1
hit  in  N_LANES  per-lane hit strobe
x_bus  out  N_LANES*COORD_W  lane i x at [i*COORD_W +: COORD_W]
y_bus  out  N_LANES*COORD_W  lane i y, same packing
vis  out  N_LANES  lane object visible
score  out  SCORE_W  hits scored, saturating at all-ones
misses  out  4  misses, saturating at MISS_LIMIT
running  out  1  FSM in RUN
game_over  out  1  FSM in OVER

Behaviour:
- Reset: state IDLE; x_bus, y_bus, vis, score, misses, running, game_over all 0; lfsr=SEED.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clock, including in IDLE and OVER. Held at SEED only while reset is high.
- FSM states: IDLE, RUN, OVER.
  - IDLE or OVER with start=1: next edge clears vis, y_bus, score and misses, and enters RUN.
  - RUN with misses==MISS_LIMIT after update: enters OVER on the same edge the limit is reached.
  - start is ignored in RUN.
  - In IDLE and OVER, all lane state, score and misses are frozen; frame_tick and hit are ignored.
- RUN, every clock:
  - Disabled lanes (i >= active_count) with vis=1: vis<=0 and y<=0 immediately; no score, no miss.
  - hit[i] with vis[i]=1 and lane enabled: vis<=0, y<=0, counts one score.
  - hit[i] with vis[i]=0 is ignored.
- RUN, on frame_tick, enabled lanes not hit this cycle:
  - vis=1: y_next = y + rate + 1, computed at COORD_W+1 bits. If y_next >= Y_MAX: vis<=0, y<=0, counts one miss. Otherwise y<=y_next.
  - vis=0: spawn. Only the lowest-index eligible lane spawns per tick, giving staggered spawning. It sets vis<=1, y<=0, x<=i*LANE_PITCH + (lfsr[COORD_W-1:0] & OFFSET_MASK), using the pre-advance lfsr value of that cycle, truncated to COORD_W.
  - A lane cleared this cycle (hit, miss or disable) cannot spawn until a later tick.
- Priority per lane in one cycle: disable > hit > edge/move > spawn.
- Counters:
  - score += number of lanes scoring this cycle, saturating at 2^SCORE_W-1.
  - misses += number of lanes missing this cycle, saturating at MISS_LIMIT.
  - Score is still taken on the cycle misses reach the limit.
- Latency: all outputs are registered; effects appear the cycle after the causing edge.
- x_bus holds its last value when vis=0.
- Reset asserted mid-game returns everything to reset values on that edge.
- active_count > N_LANES behaves as N_LANES.

Test Plan:
1. Reset high 2 clocks -> all outputs 0, running=0. Tick pulses in IDLE -> no change.
2. start=1 for one cycle, active_count=1, rate=0, then 120 ticks -> tick1 vis[0]=1, y0=0, x0 in 0..7. Tick119 y0=118. Tick120 vis[0]=0, misses=1.
3. active_count=3, rate=3, three ticks -> lanes 0, 1, 2 spawn on successive ticks. x1 in 16..23, x2 in 32..39. Each visible lane's y advances by 4 per tick.
4. Lanes 0 and 2 visible, hit=3'b101 in one cycle -> both vis bits clear, score +2. A hit on an invisible lane adds nothing.
5. MISS_LIMIT=3, force three misses -> game_over=1 and running=0 the cycle after the third miss. Further ticks and hits are ignored. start=1 -> score=0, misses=0, running=1.
6. Lane 2 visible, active_count drops 3->2 -> vis[2]=0 next cycle, score and misses unchanged. Reset mid-RUN -> all outputs 0 and state IDLE.
